// File: rtl/sel4_rr_arbiter.sv
// sel4_rr_arbiter: round-robin owner of the 4-input 2-bit selector with bounded hold time
module sel4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [1:0]        a,
    input  logic [1:0]        b,
    input  logic [1:0]        c,
    input  logic [1:0]        d,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic              busy,
    output logic [1:0]        out_dat,
    output logic              out_vld
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] GAP  = 2'b10;

    logic [1:0]        state;
    logic [1:0]        ptr;
    logic [1:0]        win;
    logic [1:0]        mux;
    logic [HOLD_W-1:0] cnt;
    logic              done;

    // scanning downward leaves the nearest requester at or after ptr as the winner
    always_comb begin
        win = ptr;
        for (int k = 3; k >= 0; k--)
            if (req[ptr + 2'(k)]) win = ptr + 2'(k);
    end

    assign mux  = sel == 2'd0 ? a : sel == 2'd1 ? b : sel == 2'd2 ? c : d;
    assign done = !req[sel] || cnt == HOLD_W'(MAX_HOLD);
    assign busy = state == BUSY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            cnt     <= '0;
            gnt     <= 4'b0000;
            sel     <= 2'd0;
            out_dat <= 2'd0;
            out_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_vld <= 1'b0;
                    if (|req) begin
                        state <= BUSY;
                        gnt   <= 4'b0001 << win;
                        sel   <= win;
                        cnt   <= HOLD_W'(1);
                    end
                end
                BUSY: begin
                    out_vld <= req[sel];
                    if (req[sel]) out_dat <= mux;
                    if (done) begin
                        state <= GAP;
                        gnt   <= 4'b0000;
                        ptr   <= sel + 2'd1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + HOLD_W'(1);
                    end
                end
                GAP: begin
                    out_vld <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= 4'b0000;
                    cnt     <= '0;
                    out_vld <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sel4_rr_arbiter.sv
// tb_sel4_rr_arbiter: random and directed stimulus on two arbiters (hold 4 and hold 1)
// against a transaction-level model of owner, hold time and turnaround.
module tb_sel4_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [1:0] a = 2'd0, b = 2'd0, c = 2'd0, d = 2'd0;
    logic [3:0] g0, g1;
    logic [1:0] s0, s1, d0, d1;
    logic       b0, b1, v0, v1;

    int checks = 0;
    int failures = 0;

    int owner[2], held[2], ptr[2], last[2], gap[2], vld[2], dat[2];
    int maxh[2] = '{4, 1};

    always #5 clk = ~clk;

    sel4_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) u_h4 (
        .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
        .gnt(g0), .sel(s0), .busy(b0), .out_dat(d0), .out_vld(v0));

    sel4_rr_arbiter #(.MAX_HOLD(1), .HOLD_W(4)) u_h1 (
        .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
        .gnt(g1), .sel(s1), .busy(b1), .out_dat(d1), .out_vld(v1));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            owner[i] = -1; held[i] = 0; ptr[i] = 0; last[i] = 0;
            gap[i] = 0; vld[i] = 0; dat[i] = 0;
        end
    endfunction

    function automatic void model_step();
        int din[4];
        din = '{int'(a), int'(b), int'(c), int'(d)};
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (owner[i] >= 0) begin
                vld[i] = int'(req[owner[i]]);
                if (req[owner[i]]) dat[i] = din[owner[i]];
                if (!req[owner[i]] || held[i] == maxh[i]) begin
                    ptr[i] = (owner[i] + 1) % 4;
                    owner[i] = -1;
                    gap[i] = 1;
                end else begin
                    held[i]++;
                end
            end else if (gap[i] != 0) begin
                gap[i] = 0;
                vld[i] = 0;
            end else begin
                vld[i] = 0;
                for (int k = 0; k < 4; k++)
                    if (owner[i] < 0 && req[(ptr[i] + k) % 4]) begin
                        owner[i] = (ptr[i] + k) % 4;
                        last[i] = owner[i];
                        held[i] = 1;
                    end
            end
        end
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            string p;
            p = i == 0 ? "h4" : "h1";
            chk({p, "_gnt"}, int'(i == 0 ? g0 : g1), owner[i] >= 0 ? (1 << owner[i]) : 0);
            chk({p, "_sel"}, int'(i == 0 ? s0 : s1), last[i]);
            chk({p, "_busy"}, int'(i == 0 ? b0 : b1), int'(owner[i] >= 0));
            chk({p, "_vld"}, int'(i == 0 ? v0 : v1), vld[i]);
            chk({p, "_dat"}, int'(i == 0 ? d0 : d1), dat[i]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_data();
        a = 2'($urandom); b = 2'($urandom); c = 2'($urandom); d = 2'($urandom);
    endtask

    task automatic async_pulse();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 check_all();
        // reset held with random activity on the inputs
        for (int n = 0; n < 4; n++) begin
            req = 4'($urandom); rand_data();
            cyc();
        end
        req = 4'b0000;
        rst_n = 1'b1;
        cyc();
        // single requester C for a short transfer, then idle
        req = 4'b0100; c = 2'b10;
        for (int n = 0; n < 4; n++) cyc();
        req = 4'b0000;
        for (int n = 0; n < 4; n++) cyc();
        // rotation: pointer sits past C, so A wins over C
        req = 4'b0101;
        for (int n = 0; n < 8; n++) begin rand_data(); cyc(); end
        req = 4'b0000;
        for (int n = 0; n < 3; n++) cyc();
        // all requesters held: fair rotation
        req = 4'b1111;
        for (int n = 0; n < 30; n++) begin rand_data(); cyc(); end
        // async reset mid-transfer, then B alone from a fresh pointer
        while (!b0) cyc();
        async_pulse();
        req = 4'b0010;
        for (int n = 0; n < 6; n++) begin rand_data(); cyc(); end
        // A alone held: hold-1 instance grants one cycle in three
        req = 4'b0001;
        for (int n = 0; n < 12; n++) begin rand_data(); cyc(); end
        // random traffic with sticky requests and occasional async resets
        for (int n = 0; n < 800; n++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(5) == 0) req[k] = ~req[k];
            rand_data();
            if ($urandom_range(60) == 0) async_pulse();
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
